// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz-class pixel clock.
package vga_timing_pkg;

  // Horizontal geometry, in pixels
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Vertical geometry, in lines
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_CNT_W    = 10;

  // Sync polarity selectors (value = active level of the pulse)
  localparam int SYNC_ACTIVE_LOW  = 0;
  localparam int SYNC_ACTIVE_HIGH = 1;

  // Single-bit registered outputs, kept together so reset/hold is one assignment
  typedef struct packed {
    logic pix_ce;
    logic hsync;
    logic vsync;
    logic video_on;
    logic line_start;
    logic frame_start;
  } vga_flags_t;

  // Bits needed to hold 0..n-1; never less than 1 so a divide-by-1 still has a register
  function automatic int clog2_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus active/sync window decode.
// Used once for the horizontal (pixel) axis and once for the vertical (line) axis.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             in_sync,
  output logic             in_active
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  // Window bounds one bit wider so an edge equal to 2**CNT_W still compares correctly
  localparam logic [CNT_W:0] ACT_END  = (CNT_W+1)'(ACTIVE);
  localparam logic [CNT_W:0] SYNC_LO  = (CNT_W+1)'(ACTIVE + FP);
  localparam logic [CNT_W:0] SYNC_HI  = (CNT_W+1)'(ACTIVE + FP + SYNC);

  logic [CNT_W:0] cnt_x;

  assign cnt_x     = {1'b0, cnt};
  assign wrap      = (cnt == LAST);
  assign in_active = (cnt_x < ACT_END);
  assign in_sync   = (cnt_x >= SYNC_LO) && (cnt_x < SYNC_HI);

  // Position: step on adv, return to 0 after the last position of the axis
  always_ff @(posedge clk or posedge clr) begin
    if (clr)      cnt <= '0;
    else if (adv) cnt <= wrap ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Produces registered sync, blanking, pixel coordinates and line/frame strobes,
// all updated on a pixel tick derived from clk by an integer divider.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame counter
// output (frame_cnt) that counts frame_start pulses since reset.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int CLK_DIV  = 1,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = clog2_w(CLK_DIV);

  localparam logic SYNC_ON   = (SYNC_POL != 0);
  localparam logic SYNC_IDLE = ~SYNC_ON;

  localparam vga_flags_t FLAGS_RST = '{
    pix_ce:      1'b0,
    hsync:       SYNC_IDLE,
    vsync:       SYNC_IDLE,
    video_on:    1'b0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  // Reject geometries the counters cannot represent
  if (H_TOTAL > (64'd1 << CNT_W)) begin : g_bad_h
    $error("vga_timing_gen: H_TOTAL exceeds 2**CNT_W");
  end
  if (V_TOTAL > (64'd1 << CNT_W)) begin : g_bad_v
    $error("vga_timing_gen: V_TOTAL exceeds 2**CNT_W");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             tick;

  logic [CNT_W-1:0] hc, vc;
  logic             h_wrap, v_wrap;
  logic             h_sync, v_sync;
  logic             h_act, v_act;
  logic             v_adv;

  // line_q / origin_q: the position about to be presented is column 0 / the
  // frame origin. Derived from the wrap of the previous tick so no wide
  // compare against zero is needed.
  logic             line_q, origin_q;

  vga_flags_t       flags_q;
  logic [CNT_W-1:0] px_q, py_q;

  assign tick  = en && (div == DIV_LAST);
  assign v_adv = tick && h_wrap;

  // Pixel-clock divider: free-runs while enabled, restarts after each tick
  always_ff @(posedge clk or posedge clr) begin
    if (clr)     div <= '0;
    else if (en) div <= tick ? '0 : div + 1'b1;
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .clk       (clk),
    .clr       (clr),
    .adv       (tick),
    .cnt       (hc),
    .wrap      (h_wrap),
    .in_sync   (h_sync),
    .in_active (h_act)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .clk       (clk),
    .clr       (clr),
    .adv       (v_adv),
    .cnt       (vc),
    .wrap      (v_wrap),
    .in_sync   (v_sync),
    .in_active (v_act)
  );

  // Track whether the next presented position starts a line / a frame
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      line_q   <= 1'b1;
      origin_q <= 1'b1;
    end else if (tick) begin
      line_q   <= h_wrap;
      origin_q <= h_wrap && v_wrap;
    end
  end

  // Output register: capture decode of (hc,vc) on tick; strobes last one clk
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      flags_q <= FLAGS_RST;
      px_q    <= '0;
      py_q    <= '0;
    end else if (tick) begin
      flags_q.pix_ce      <= 1'b1;
      flags_q.hsync       <= h_sync ? SYNC_ON : SYNC_IDLE;
      flags_q.vsync       <= v_sync ? SYNC_ON : SYNC_IDLE;
      flags_q.video_on    <= h_act && v_act;
      flags_q.line_start  <= line_q;
      flags_q.frame_start <= origin_q;
      px_q                <= hc;
      py_q                <= vc;
    end else begin
      flags_q.pix_ce      <= 1'b0;
      flags_q.line_start  <= 1'b0;
      flags_q.frame_start <= 1'b0;
    end
  end

  assign pix_ce      = flags_q.pix_ce;
  assign hsync       = flags_q.hsync;
  assign vsync       = flags_q.vsync;
  assign video_on    = flags_q.video_on;
  assign line_start  = flags_q.line_start;
  assign frame_start = flags_q.frame_start;
  assign pixel_x     = px_q;
  assign pixel_y     = py_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frames presented since reset; bumps on the same edge that raises frame_start
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                   frame_cnt <= '0;
    else if (tick && origin_q) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen. Two instances on a shrunken raster
// (15x10 positions): one active-low with a divide-by-3 pixel clock, one
// active-high with divide-by-1. Expected outputs come from counting enabled
// clocks since reset and mapping the tick count onto raster coordinates.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 5, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int W  = 6;
  localparam int DIV_A = 3;
  localparam int DIV_B = 1;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic en  = 1'b0;

  logic         a_ce, a_hs, a_vs, a_vo, a_ls, a_fs;
  logic [W-1:0] a_px, a_py;
  logic         b_ce, b_hs, b_vs, b_vo, b_ls, b_fs;
  logic [W-1:0] b_px, b_py;
  logic [15:0]  a_fc, b_fc;

`ifndef VGA_TIMING_FRAME_CNT_EN
  assign a_fc = '0;
  assign b_fc = '0;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .CLK_DIV(DIV_A), .CNT_W(W)
  ) u_dut_a (
    .clk(clk), .clr(clr), .en(en),
    .pix_ce(a_ce), .hsync(a_hs), .vsync(a_vs), .video_on(a_vo),
    .pixel_x(a_px), .pixel_y(a_py), .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(a_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1), .CLK_DIV(DIV_B), .CNT_W(W)
  ) u_dut_b (
    .clk(clk), .clr(clr), .en(en),
    .pix_ce(b_ce), .hsync(b_hs), .vsync(b_vs), .video_on(b_vo),
    .pixel_x(b_px), .pixel_y(b_py), .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(b_fc)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: enabled clocks since reset, and whether the last edge was enabled
  int ecnt    = 0;
  bit edge_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected view of one instance given its divider ratio and sync polarity
  task automatic check_dut(input string p, input int dv, input bit pol,
                           input logic ce, input logic hs, input logic vs,
                           input logic vo, input logic ls, input logic fs,
                           input logic [W-1:0] px, input logic [W-1:0] py,
                           input logic [15:0] fc);
    int n, pos, x, y;
    bit stb, hact, vact;
    n   = ecnt / dv;
    stb = edge_en && (n > 0) && (ecnt % dv == 0);
    if (n == 0) begin
      pos = -1; x = 0; y = 0;
    end else begin
      pos = (n - 1) % (HT * VT);
      x   = pos % HT;
      y   = pos / HT;
    end
    hact = (n > 0) && (x >= HA + HF) && (x < HA + HF + HS);
    vact = (n > 0) && (y >= VA + VF) && (y < VA + VF + VS);
    check({p, ".pix_ce"},      ce, stb);
    check({p, ".hsync"},       hs, hact ? pol : !pol);
    check({p, ".vsync"},       vs, vact ? pol : !pol);
    check({p, ".video_on"},    vo, (n > 0) && (x < HA) && (y < VA));
    check({p, ".pixel_x"},     px, x);
    check({p, ".pixel_y"},     py, y);
    check({p, ".line_start"},  ls, stb && (x == 0));
    check({p, ".frame_start"}, fs, stb && (pos == 0));
`ifdef VGA_TIMING_FRAME_CNT_EN
    check({p, ".frame_cnt"},   fc, (n == 0) ? 0 : (((n - 1) / (HT * VT) + 1) % 65536));
`else
    if (fc !== 16'd0) check({p, ".frame_cnt_tie"}, fc, 0);
`endif
  endtask

  // One clk: drive on the falling edge, advance the model on the rising edge, sample 1 ns later
  task automatic step(input bit c, input bit e);
    bit was_clr;
    @(negedge clk);
    was_clr = clr;
    clr = c;
    en  = e;
    if (c && !was_clr) begin
      #1;
      check("clr_async.pixel_x",  a_px, 0);
      check("clr_async.video_on", a_vo, 0);
      check("clr_async.a_hsync",  a_hs, 1);
      check("clr_async.b_vsync",  b_vs, 0);
    end
    @(posedge clk);
    if (clr) begin
      ecnt    = 0;
      edge_en = 1'b0;
    end else if (en) begin
      ecnt++;
      edge_en = 1'b1;
    end else begin
      edge_en = 1'b0;
    end
    #1;
    check_dut("a", DIV_A, 1'b0, a_ce, a_hs, a_vs, a_vo, a_ls, a_fs, a_px, a_py, a_fc);
    check_dut("b", DIV_B, 1'b1, b_ce, b_hs, b_vs, b_vo, b_ls, b_fs, b_px, b_py, b_fc);
  endtask

  initial begin
    // Held in reset, then a full-speed run through several frames of both instances
    repeat (3) step(1'b1, 1'b0);
    repeat (1000) step(1'b0, 1'b1);

    // Randomized enable with rare mid-frame clears
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        repeat ($urandom_range(1, 2)) step(1'b1, $urandom_range(0, 1) == 1);
      end else begin
        step(1'b0, $urandom_range(0, 9) != 0);
      end
    end

    // Long pause mid-line: everything must freeze with no strobes
    repeat (40) step(1'b0, 1'b1);
    repeat (50) step(1'b0, 1'b0);
    repeat (30) step(1'b0, 1'b1);

    // Clear in the middle of a frame, then restart from the origin
    repeat (200) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (600) step(1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator producing sync, blanking, pixel coordinates and line/frame strobes for any mode described by porch/sync widths. It supersedes the fixed 640x480 sync counter with configurable geometry, sync polarity, an integrated pixel-clock divider, pause control and registered, glitch-free outputs. It sits between the board clock and the game's pixel renderers; renderers sample outputs when `pix_ce` is high.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, active level of hsync/vsync (0 = active-low)
- `CLK_DIV`, 1, clk cycles per pixel (>=1)
- `CNT_W`, 10, width of counters and pixel_x/pixel_y
- `clk` input 1 system clock; everything is single-clock
- `clr` input 1 asynchronous, active-high reset
- `en` input 1 run enable; 0 freezes divider, counters and outputs
- `pix_ce` output 1 high for the first clk of each new output pixel
- `hsync` output 1 horizontal sync, level per SYNC_POL
- `vsync` output 1 vertical sync, level per SYNC_POL
- `video_on` output 1 high inside active area
- `pixel_x` output CNT_W horizontal position (0..H_TOTAL-1)
- `pixel_y` output CNT_W vertical position (0..V_TOTAL-1)
- `line_start` output 1 one-clk pulse at pixel_x==0
- `frame_start` output 1 one-clk pulse at pixel_x==0 && pixel_y==0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Elaboration error if either exceeds 2**CNT_W, or if CLK_DIV<1.
- Line order: active, front porch, sync, back porch; position 0 is the first visible pixel.
- Divider `div` counts 0..CLK_DIV-1 while en=1; tick = en && div==CLK_DIV-1. CLK_DIV=1: tick every clk with en=1.
- On tick: outputs register the decode of current (hc,vc); then hc advances; at hc==H_TOTAL-1, hc wraps to 0 and vc advances; at vc==V_TOTAL-1 with hc wrap, vc wraps to 0.
- Decode: video_on = hc<H_ACTIVE && vc<V_ACTIVE; hsync = SYNC_POL when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, else !SYNC_POL; vsync same on vc with V parameters; pixel_x=hc, pixel_y=vc.
- en=0: no tick; div, hc, vc, and level outputs hold; strobes and pix_ce drop after their single clk.
- Counter arithmetic is unsigned CNT_W; no overflow because of the elaboration check.

## Timing
- Reset values: div=0, hc=0, vc=0, pix_ce=0, video_on=0, pixel_x=0, pixel_y=0, line_start=0, frame_start=0, hsync=vsync=!SYNC_POL.
- Latency: outputs, pix_ce and strobes change on the clk edge where tick is high and remain valid for CLK_DIV clks. pix_ce, line_start and frame_start are high only for the first of those clks.
- First tick after reset release presents (0,0): video_on=1, line_start=1, frame_start=1.
- clr mid-frame: immediate return to reset values; restart at (0,0) on the next tick.
- en deasserted on a tick clk: that tick still completes.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined: adds output `frame_cnt` [15:0]. It resets to 0 and increments (wrapping at 16'hFFFF) on each edge that raises frame_start. The first frame after reset reads 1.
- Not defined: port and counter absent; all other behaviour is identical.

## Structure
- Package `vga_timing_pkg`: default 640x480@60 constants (H/V active, porches, sync), a `SYNC_ACTIVE_LOW` constant, and a `clog2`-style width helper.
- Sub-module `vga_axis_counter`, instantiated twice (horizontal, vertical): it has a wrap counter with an advance input, a wrap output, and an in-sync-window decode.

## Test plan
- Defaults, CLK_DIV=1: after reset, first tick -> pixel_x=0, pixel_y=0, video_on=1, frame_start=1. hsync low exactly for pixel_x 656..751 (96 clks).
- Defaults: vsync low only while pixel_y is 490..491 (1600 clks). The next frame_start occurs 420000 clks after the first.
- CLK_DIV=4: pix_ce period is 4 clks, and outputs are stable for 4 clks. The line_start period is 3200 clks.
- SYNC_POL=1: hsync/vsync reset high-inactive → reset to 0; active pulses are high, with the same windows as above.
- Hold en=0 for 50 clks at pixel_x=100: all outputs frozen, with no pix_ce or strobes. On resume, pixel_x=101 appears on the next tick.
- Assert clr at pixel (300,200): all outputs take reset values on the same edge. After release, the first tick gives (0,0) with frame_start=1. With the macro defined, frame_cnt=1.
